jk_bank_arbiter: RTL and testbench

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

---
 rtl/jk_arb_pkg.sv | 21 ++
 rtl/jk_bank.sv | 43 ++++
 rtl/jk_bank_arbiter.sv | 113 +++++++++++
 tb/tb_jk_bank_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_arb_pkg.sv
// Shared types and constants for the JK bank arbiter: FSM states, JK command
// encodings and default sizing.
package jk_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int NBITS_DEF = 8;
  localparam int IDXW_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  // {j,k} command encodings
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TGL  = 2'b11;

endpackage

// File: rtl/jk_bank.sv
// Bank of NBITS JK flip-flops with per-bit j/k inputs and a synchronous clear
// that takes priority over any JK update on the same edge.
module jk_bank
  import jk_arb_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [NBITS-1:0] j,
  input  logic [NBITS-1:0] k,
  output logic [NBITS-1:0] q
);

  logic [NBITS-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    for (int b = 0; b < NBITS; b++) begin
      case ({j[b], k[b]})
        HOLD: q_d[b] = q_q[b];
        RST:  q_d[b] = 1'b0;
        SET:  q_d[b] = 1'b1;
        TGL:  q_d[b] = ~q_q[b];
      endcase
    end
    if (clr) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that lets NREQ requesters issue JK commands to a shared
// bank, one transaction every three cycles (IDLE -> APPLY -> DONE).
module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NBITS = NBITS_DEF,
  parameter int IDXW  = IDXW_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    cmd,
  input  logic [IDXW*NREQ-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic                 done,
  output logic                 busy,
  output logic [NBITS-1:0]     q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, win;
  logic [1:0]       cmd_q, cmd_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             done_q, done_d;
  logic [NBITS-1:0] sel, j_vec, k_vec;

  // First requesting index strictly after the last winner, wrapping around.
  always_comb begin
    int   cand;
    logic found;
    cand  = 0;
    found = 1'b0;
    win   = ptr_q;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(ptr_q) + i) % NREQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = PW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    gnt_d   = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = APPLY;
          ptr_d   = win;
          cmd_d   = cmd[2*int'(win) +: 2];
          idx_d   = idx[IDXW*int'(win) +: IDXW];
          gnt_d   = NREQ'(1) << win;
        end
      end
      APPLY: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      gnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  // Latched command/index are only consumed while in APPLY, so no reset needed.
  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
    idx_q <= idx_d;
  end

  assign sel   = NBITS'(1) << idx_q;
  assign j_vec = (state_q == APPLY && cmd_q[1]) ? sel : '0;
  assign k_vec = (state_q == APPLY && cmd_q[0]) ? sel : '0;

  jk_bank #(
    .NBITS(NBITS)
  ) u_bank (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr),
    .j      (j_vec),
    .k      (k_vec),
    .q      (q)
  );

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: a transaction-level reference model
// predicts each completed transaction; a negedge monitor checks them.
module tb_jk_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int IDXW  = 3;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 clr;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    cmd;
  logic [IDXW*NREQ-1:0] idx;
  logic [NREQ-1:0]      gnt;
  logic                 done;
  logic                 busy;
  logic [NBITS-1:0]     q;

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .IDXW(IDXW)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .req(req), .cmd(cmd), .idx(idx),
    .gnt(gnt), .done(done), .busy(busy), .q(q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int               done_cyc;
    logic [NREQ-1:0]  gnt;
    logic [NBITS-1:0] q;
  } item_t;

  item_t sb[$];
  int    seen_win[$];
  int    seen_cyc[$];

  // Reference model state: bank contents, last winner, first edge at which the
  // arbiter can accept again, and the one command awaiting its apply edge.
  logic [NBITS-1:0] m_q;
  int m_ptr, m_free;
  bit p_valid;
  int p_edge, p_bit, p_cmd, p_win;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(int r, int c, int i);
    cmd[2*r +: 2]       = 2'(c);
    idx[IDXW*r +: IDXW] = IDXW'(i);
  endtask

  task automatic model_reset();
    p_valid = 0;
    m_q     = '0;
    m_ptr   = NREQ - 1;
    m_free  = 0;
  endtask

  // Evaluate the model for the edge about to happen (edge number == cyc now).
  task automatic model_eval();
    int    k;
    bit    applied;
    item_t it;
    k       = cyc;
    applied = 0;
    if (p_valid && p_edge == k) begin
      if (p_cmd == 1) m_q[p_bit] = 1'b0;
      else if (p_cmd == 2) m_q[p_bit] = 1'b1;
      else if (p_cmd == 3) m_q[p_bit] = ~m_q[p_bit];
      p_valid = 0;
      applied = 1;
    end
    if (clr) m_q = '0;
    if (applied) begin
      it.done_cyc = k + 1;
      it.gnt      = NREQ'(1 << p_win);
      it.q        = m_q;
      sb.push_back(it);
    end
    if (k >= m_free && req != '0) begin
      for (int i = 1; i <= NREQ; i++) begin
        int c;
        c = (m_ptr + i) % NREQ;
        if (req[c]) begin
          p_win = c;
          break;
        end
      end
      m_ptr   = p_win;
      p_cmd   = int'(cmd[2*p_win +: 2]);
      p_bit   = int'(idx[IDXW*p_win +: IDXW]);
      p_valid = 1;
      p_edge  = k + 1;
      m_free  = k + 3;
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      model_eval();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    req = '0;
    clr = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  // Monitor: per-cycle grant sanity, and scoreboard pop on every done pulse.
  initial begin
    logic [NREQ-1:0] prev_gnt;
    item_t it;
    int w;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("gnt_onehot", ($countones(gnt) <= 1), 1);
        if (gnt != '0) chk("busy_in_apply", busy, 1);
        if (done) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no transaction", cyc);
          end else begin
            it = sb.pop_front();
            chk("done_cycle", cyc, it.done_cyc);
            chk("gnt_before_done", prev_gnt, it.gnt);
            chk("q_at_done", q, it.q);
            chk("gnt_in_done", gnt, 0);
            chk("busy_in_done", busy, 1);
          end
          w = -1;
          for (int i = 0; i < NREQ; i++) if (prev_gnt[i]) w = i;
          seen_win.push_back(w);
          seen_cyc.push_back(cyc);
        end
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected run to finish");
    $fatal(1);
  end

  initial begin
    int exp_o[5];
    reset_n = 1'b1;
    clr     = 1'b0;
    req     = '0;
    cmd     = '0;
    idx     = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single set of bit 3 by requester 0.
    set_req(0, 2, 3);
    req = 4'b0001;
    tick();
    chk("s1_gnt", gnt, 4'b0001);
    req = '0;
    tick();
    chk("s1_done", done, 1);
    chk("s1_q", q, 8'h08);
    tick(2);
    chk("s1_idle", busy, 0);

    // All four toggling distinct bits with requests held.
    do_reset();
    seen_win.delete();
    seen_cyc.delete();
    for (int r = 0; r < NREQ; r++) set_req(r, 3, r);
    req = 4'b1111;
    tick(13);
    req = '0;
    tick(3);
    exp_o = '{0, 1, 2, 3, 0};
    chk("s2_count", seen_win.size(), 5);
    for (int i = 0; i < 5 && i < seen_win.size(); i++) chk("s2_order", seen_win[i], exp_o[i]);
    for (int i = 1; i < 5 && i < seen_cyc.size(); i++) chk("s2_spacing", seen_cyc[i] - seen_cyc[i-1], 3);
    chk("s2_q", q, 8'h0E);

    // Two toggles of bit 5 cancel out.
    do_reset();
    seen_win.delete();
    set_req(1, 3, 5);
    set_req(2, 3, 5);
    req = 4'b0110;
    tick(4);
    req = '0;
    tick(3);
    chk("s3_q5", q[5], 0);
    chk("s3_count", seen_win.size(), 2);
    if (seen_win.size() == 2) begin
      chk("s3_first", seen_win[0], 1);
      chk("s3_second", seen_win[1], 2);
    end

    // Clear during APPLY wins over the set; done still pulses.
    do_reset();
    set_req(0, 2, 7);
    req = 4'b0001;
    tick();
    req = '0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("s4_q", q, 8'h00);
    chk("s4_done", done, 1);
    tick(2);

    // Reset in APPLY aborts the transaction; requester 0 wins afterwards.
    do_reset();
    set_req(3, 2, 6);
    req = 4'b1000;
    tick();
    req = '0;
    tick(2);
    chk("s5_q_pre", q, 8'h40);
    set_req(2, 2, 2);
    req = 4'b0100;
    tick();
    chk("s5_gnt_pre", gnt, 4'b0100);
    do_reset();
    seen_win.delete();
    tick(3);
    chk("s5_no_done", seen_win.size(), 0);
    for (int r = 0; r < NREQ; r++) set_req(r, 2, r);
    req = 4'b1111;
    tick();
    chk("s5_gnt0", gnt, 4'b0001);
    req = '0;
    tick(3);
    chk("s5_q_post", q, 8'h01);

    // Command changed during APPLY: the latched set is applied.
    set_req(1, 2, 4);
    req = 4'b0010;
    tick();
    set_req(1, 1, 4);
    req = '0;
    tick();
    chk("s6_q4", q[4], 1);
    tick(2);

    // Randomised traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) req = NREQ'($urandom);
      for (int r = 0; r < NREQ; r++) set_req(r, $urandom_range(0, 3), $urandom_range(0, NBITS - 1));
      clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    req = '0;
    clr = 1'b0;
    tick(4);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
